tlb_maint_ctrl: RTL and testbench
=================================

# tlb_maint_ctrl

Sequencer for TLB maintenance instructions (TLBSRCH, TLBRD, TLBWR, TLBFILL, INVTLB) in front of the MMU's register-based TLB array. It accepts one committed maintenance request at a time and steps through the array one entry per cycle using a read port. It drives the MMU's one-hot write request to modify entries, and returns search/read results and the CSR update data to the commit stage.

## Interface
- TLB_ENTRY_NUM, 64: number of TLB entries, power of two.
- IDX_W, $clog2(TLB_ENTRY_NUM): entry index width.

- clk  in  1  clock, single domain.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  maintenance request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  3  tlb_op_e: 0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; others illegal.
- req_invop  in  5  INVTLB op field, 0..6 legal.
- req_asid  in  10  INVTLB asid operand.
- req_va  in  32  INVTLB va operand.
- csr  in  csr_t  tlbidx/tlbehi/tlbelo0/tlbelo1/asid, sampled at accept.
- rd_idx_o  out  IDX_W  TLB read index.
- rd_entry_i  in  tlb_entry_t  entry at rd_idx_o, same cycle, combinational.
- tlb_write_req_o  out  tlb_write_req_t  one-hot write strobe plus entry, to MMU.
- resp_valid  out  1  one-cycle completion pulse.
- resp_hit  out  1  SRCH hit.
- resp_idx  out  IDX_W  SRCH hit index.
- resp_entry  out  tlb_entry_t  RD result.
- resp_ne  out  1  RD/SRCH not-exist flag.
- resp_err  out  1  illegal op/invop; no TLB change.

## Operation
- States: IDLE, SRCH, RD, WR, INV, DONE (maint_state_e).
- IDLE: accept on req_valid&&req_ready. Latch op, invop, asid, va, and csr fields into operand registers. Clear the scan counter. Go to the op's state; an illegal op or invop goes to DONE with resp_err=1.
- SRCH: rd_idx_o=cnt; match = e && (g || asid==latched csr.asid) && vppn match.
  - Huge page compares vppn[18:9] only; 4 KB compares all 19 bits.
  - On match: record idx, go to DONE with hit=1, ne=0.
  - At cnt==N-1 with no match: go to DONE with hit=0, ne=1.
- RD: rd_idx_o = latched tlbidx.index[IDX_W-1:0]. Capture rd_entry_i into resp_entry; resp_ne = ~entry.e. Go to DONE.
- WR/FILL: build the entry from latched tlbehi/tlbelo0/tlbelo1/tlbidx.ps/asid, with e = ~tlbidx.ne and huge_page = (ps==21).
  - Target index: tlbidx.index for WR; fill counter for FILL.
  - Assert the one-hot write for one cycle, then go to DONE.
- INV: rd_idx_o=cnt each cycle.
  - If the entry satisfies the invop predicate, issue a one-hot write of the same entry with e=0.
  - invop 0/1: all entries. 2: g=1. 3: g=0. 4: g=0 && asid match. 5: g=0 && asid match && va match. 6: (g=1 || asid match) && va match.
  - After cnt==N-1, go to DONE.
- DONE: resp_valid=1 for one cycle, then IDLE. resp_* hold until the next accept.
- Fill counter: IDX_W-bit free-running increment every clock, independent of state; reset 0.
- No flush: requests are issued at commit and always complete.

## Timing
- Reset: state=IDLE, req_ready=1, cnt=0, fill counter=0. resp_valid, resp_hit, resp_ne and resp_err are 0, resp_idx=0, resp_entry='0. tlb_write_req_o='0, rd_idx_o=0.
- Accept at cycle T. Completion (resp_valid):
  - RD/WR/FILL/illegal: T+2.
  - SRCH hitting index k: T+k+2; miss: T+N+1.
  - INV: T+N+1.
- WR/FILL write strobe is at T+1.
- INV write strobe for index k is at T+1+k, at most one bit set per cycle.
- A write issued in cycle t is visible on rd_entry_i from t+1. INV never rereads an index, so no hazard.
- req_ready=0 from T+1 through the DONE cycle. The next accept is possible the cycle after DONE.
- Reset mid-scan: immediate return to IDLE. Writes already issued persist; no partial-entry write is possible.

## Structure
- a_mmu_defines gains tlb_op_e, maint_state_e, an invop constants list, and tlb_maint_resp_t.
- Sub-module tlb_entry_match: combinational key/asid/vppn compare taking (key, asid, va, check_g, check_asid, check_va). It is shared by SRCH and INV predicates.
- The controller holds only the FSM, operand/result registers, and the counters.

## Test plan
- WR with tlbidx.index=5, ne=0, ps=12 -> tlb_write_req bit 5 only at T+1; RD index 5 returns the same key/values, resp_ne=0, resp_valid at T+2.
- SRCH with a match only at entry 9 (g=0, asid=0x3) and csr.asid=0x3 -> resp_hit=1, resp_idx=9, resp_valid at T+11. The same with csr.asid=0x4 -> resp_hit=0, resp_ne=1 at T+65.
- INV invop 5, asid=0x3, va=0x00402000 over entries {3: g=0 asid 3 match, 4: g=1 same va, 7: asid 2} -> only index 3 is written with e=0, resp_valid at T+65.
- FILL twice, 2 clocks apart -> write indices differ by the elapsed cycle count mod 64; invop=7 or op=6 -> resp_err=1 at T+2, no write.
- rst_n low at T+20 during INV invop 0 -> entries 0..18 invalidated, later entries unchanged, all outputs at reset values; a new request is accepted right after release.

Source files
------------

// File: rtl/tlb_maint_ctrl_pkg.sv
// Shared types and constants for the TLB maintenance sequencer.
// Covers op/state encodings, INVTLB op codes, CSR/entry layouts and the write strobe.
package tlb_maint_ctrl_pkg;

    localparam int TLB_ENTRY_NUM = 64;
    localparam int IDX_W         = $clog2(TLB_ENTRY_NUM);

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } tlb_op_e;

    typedef logic [2:0] maint_state_e;
    localparam maint_state_e S_IDLE = 3'd0;
    localparam maint_state_e S_SRCH = 3'd1;
    localparam maint_state_e S_RD   = 3'd2;
    localparam maint_state_e S_WR   = 3'd3;
    localparam maint_state_e S_INV  = 3'd4;
    localparam maint_state_e S_DONE = 3'd5;

    localparam logic [4:0] INVOP_ALL        = 5'd0;
    localparam logic [4:0] INVOP_ALL_ALT    = 5'd1;
    localparam logic [4:0] INVOP_G          = 5'd2;
    localparam logic [4:0] INVOP_NG         = 5'd3;
    localparam logic [4:0] INVOP_NG_ASID    = 5'd4;
    localparam logic [4:0] INVOP_NG_ASID_VA = 5'd5;
    localparam logic [4:0] INVOP_G_ASID_VA  = 5'd6;

    // Global-bit qualifier modes for tlb_entry_match
    localparam logic [1:0] GCHK_ANY     = 2'd0;
    localparam logic [1:0] GCHK_SET     = 2'd1;
    localparam logic [1:0] GCHK_CLR     = 2'd2;
    localparam logic [1:0] GCHK_OR_ASID = 2'd3;

    typedef struct packed {
        logic [19:0] ppn;
        logic [1:0]  plv;
        logic [1:0]  mat;
        logic        d;
        logic        v;
    } tlb_lo_t;

    typedef struct packed {
        logic        e;
        logic        huge_page;
        logic [5:0]  ps;
        logic        g;
        logic [9:0]  asid;
        logic [18:0] vppn;
        tlb_lo_t     lo0;
        tlb_lo_t     lo1;
    } tlb_entry_t;

    typedef struct packed {
        logic        ne;
        logic [5:0]  ps;
        logic [15:0] index;
    } tlbidx_t;

    typedef struct packed {
        logic [19:0] ppn;
        logic        g;
        logic [1:0]  mat;
        logic [1:0]  plv;
        logic        d;
        logic        v;
    } tlbelo_t;

    typedef struct packed {
        tlbidx_t     tlbidx;
        logic [18:0] tlbehi;
        tlbelo_t     tlbelo0;
        tlbelo_t     tlbelo1;
        logic [9:0]  asid;
    } csr_t;

    typedef struct packed {
        logic [TLB_ENTRY_NUM-1:0] we;
        tlb_entry_t               entry;
    } tlb_write_req_t;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] idx;
        tlb_entry_t       entry;
        logic             ne;
        logic             err;
    } tlb_maint_resp_t;

endpackage

// File: rtl/tlb_maint_ctrl_if.sv
// Commit-stage request/response bundle for the TLB maintenance sequencer.
interface tlb_maint_ctrl_if;
    import tlb_maint_ctrl_pkg::*;

    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_op;
    logic [4:0]       req_invop;
    logic [9:0]       req_asid;
    logic [31:0]      req_va;
    csr_t             csr;

    logic             resp_valid;
    logic             resp_hit;
    logic [IDX_W-1:0] resp_idx;
    tlb_entry_t       resp_entry;
    logic             resp_ne;
    logic             resp_err;

    modport master (
        output req_valid, req_op, req_invop, req_asid, req_va, csr,
        input  req_ready, resp_valid, resp_hit, resp_idx, resp_entry, resp_ne, resp_err
    );

    modport slave (
        input  req_valid, req_op, req_invop, req_asid, req_va, csr,
        output req_ready, resp_valid, resp_hit, resp_idx, resp_entry, resp_ne, resp_err
    );

endinterface

// File: rtl/tlb_maint_ctrl_match.sv
// Combinational entry qualifier shared by TLBSRCH and the INVTLB predicates.
// The caller ANDs in the valid bit where it matters; va is VA[31:13].
module tlb_entry_match
    import tlb_maint_ctrl_pkg::*;
(
    input  tlb_entry_t  key,
    input  logic [9:0]  asid,
    input  logic [18:0] va,
    input  logic [1:0]  check_g,
    input  logic        check_asid,
    input  logic        check_va,
    output logic        match
);
    logic asid_hit;
    logic va_hit;
    logic g_ok;
    logic unused_key;

    assign asid_hit = (key.asid == asid);
    // Huge pages cover 2^9 small pages, so only the upper vppn bits participate
    assign va_hit   = key.huge_page ? (key.vppn[18:9] == va[18:9]) : (key.vppn == va);

    always_comb begin
        g_ok = 1'b1;
        case (check_g)
            GCHK_SET:     g_ok = key.g;
            GCHK_CLR:     g_ok = !key.g;
            GCHK_OR_ASID: g_ok = key.g || asid_hit;
            default:      g_ok = 1'b1;
        endcase
    end

    assign match = g_ok && (!check_asid || asid_hit) && (!check_va || va_hit);

    assign unused_key = ^{key.e, key.ps, key.lo0, key.lo1};

endmodule

// File: rtl/tlb_maint_ctrl.sv
// TLB maintenance sequencer: one committed op at a time, one array entry per cycle.
//   state  | meaning
//   IDLE   | ready for a request, operands latched on accept
//   SRCH   | scan entries for a key match, stop at first hit
//   RD     | read the entry at the latched tlbidx.index
//   WR     | single-cycle write strobe for WR/FILL (masked for illegal ops)
//   INV    | scan all entries, clear e on predicate match
//   DONE   | resp_valid pulse
module tlb_maint_ctrl
    import tlb_maint_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    tlb_maint_ctrl_if.slave  ifc,
    output logic [IDX_W-1:0] rd_idx_o,
    input  tlb_entry_t       rd_entry_i,
    output tlb_write_req_t   tlb_write_req_o
);
    maint_state_e     state;
    logic [IDX_W-1:0] cnt;
    logic [IDX_W-1:0] fill_cnt;
    logic [IDX_W-1:0] wr_idx_q;
    logic [IDX_W-1:0] wr_tgt;
    logic [2:0]       op_q;
    logic [4:0]       invop_q;
    logic [9:0]       asid_q;
    logic [18:0]      va_q;
    tlb_entry_t       op_entry_q;
    tlb_entry_t       acc_entry;
    tlb_maint_resp_t  resp_q;

    logic             req_illegal;
    logic [9:0]       m_asid;
    logic [18:0]      m_va;
    logic [1:0]       m_check_g;
    logic             m_check_asid;
    logic             m_check_va;
    logic             m_match;
    logic             unused_bits;

    assign req_illegal = (ifc.req_op > OP_INV) ||
                         ((ifc.req_op == OP_INV) && (ifc.req_invop > INVOP_G_ASID_VA));

    // The WR/FILL image is built at accept; its asid/vppn also serve as the SRCH key
    always_comb begin
        acc_entry           = '0;
        acc_entry.e         = ~ifc.csr.tlbidx.ne;
        acc_entry.huge_page = (ifc.csr.tlbidx.ps == 6'd21);
        acc_entry.ps        = ifc.csr.tlbidx.ps;
        acc_entry.g         = ifc.csr.tlbelo0.g & ifc.csr.tlbelo1.g;
        acc_entry.asid      = ifc.csr.asid;
        acc_entry.vppn      = ifc.csr.tlbehi;
        acc_entry.lo0       = '{ppn: ifc.csr.tlbelo0.ppn, plv: ifc.csr.tlbelo0.plv,
                                mat: ifc.csr.tlbelo0.mat, d: ifc.csr.tlbelo0.d, v: ifc.csr.tlbelo0.v};
        acc_entry.lo1       = '{ppn: ifc.csr.tlbelo1.ppn, plv: ifc.csr.tlbelo1.plv,
                                mat: ifc.csr.tlbelo1.mat, d: ifc.csr.tlbelo1.d, v: ifc.csr.tlbelo1.v};
    end

    always_comb begin
        m_asid       = op_entry_q.asid;
        m_va         = op_entry_q.vppn;
        m_check_g    = GCHK_OR_ASID;
        m_check_asid = 1'b0;
        m_check_va   = 1'b1;
        if (state == S_INV) begin
            m_asid = asid_q;
            m_va   = va_q;
            case (invop_q)
                INVOP_G:          begin m_check_g = GCHK_SET;     m_check_asid = 1'b0; m_check_va = 1'b0; end
                INVOP_NG:         begin m_check_g = GCHK_CLR;     m_check_asid = 1'b0; m_check_va = 1'b0; end
                INVOP_NG_ASID:    begin m_check_g = GCHK_CLR;     m_check_asid = 1'b1; m_check_va = 1'b0; end
                INVOP_NG_ASID_VA: begin m_check_g = GCHK_CLR;     m_check_asid = 1'b1; m_check_va = 1'b1; end
                INVOP_G_ASID_VA:  begin m_check_g = GCHK_OR_ASID; m_check_asid = 1'b0; m_check_va = 1'b1; end
                default:          begin m_check_g = GCHK_ANY;     m_check_asid = 1'b0; m_check_va = 1'b0; end
            endcase
        end
    end

    tlb_entry_match u_match (
        .key        (rd_entry_i),
        .asid       (m_asid),
        .va         (m_va),
        .check_g    (m_check_g),
        .check_asid (m_check_asid),
        .check_va   (m_check_va),
        .match      (m_match)
    );

    assign wr_tgt   = (op_q == OP_FILL) ? fill_cnt : wr_idx_q;
    assign rd_idx_o = (state == S_RD) ? wr_idx_q : cnt;

    always_comb begin
        tlb_write_req_o = '0;
        if ((state == S_WR) && !resp_q.err) begin
            tlb_write_req_o.we    = TLB_ENTRY_NUM'(1) << wr_tgt;
            tlb_write_req_o.entry = op_entry_q;
        end else if ((state == S_INV) && m_match) begin
            tlb_write_req_o.we      = TLB_ENTRY_NUM'(1) << cnt;
            tlb_write_req_o.entry   = rd_entry_i;
            tlb_write_req_o.entry.e = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fill_cnt <= '0;
        else        fill_cnt <= fill_cnt + IDX_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            op_q       <= '0;
            invop_q    <= '0;
            asid_q     <= '0;
            va_q       <= '0;
            wr_idx_q   <= '0;
            op_entry_q <= '0;
            resp_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (ifc.req_valid) begin
                        op_q       <= ifc.req_op;
                        invop_q    <= ifc.req_invop;
                        asid_q     <= ifc.req_asid;
                        va_q       <= ifc.req_va[31:13];
                        wr_idx_q   <= ifc.csr.tlbidx.index[IDX_W-1:0];
                        op_entry_q <= acc_entry;
                        cnt        <= '0;
                        resp_q     <= '{hit: 1'b0, idx: '0, entry: '0, ne: 1'b0, err: req_illegal};
                        // Illegal ops ride the masked WR slot so they finish with the other single-step ops
                        if (req_illegal) begin
                            state <= S_WR;
                        end else begin
                            case (ifc.req_op)
                                OP_SRCH: state <= S_SRCH;
                                OP_RD:   state <= S_RD;
                                OP_INV:  state <= S_INV;
                                default: state <= S_WR;
                            endcase
                        end
                    end
                end
                S_SRCH: begin
                    if (rd_entry_i.e && m_match) begin
                        resp_q.hit <= 1'b1;
                        resp_q.idx <= cnt;
                        state      <= S_DONE;
                    end else if (&cnt) begin
                        resp_q.ne <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + IDX_W'(1);
                    end
                end
                S_RD: begin
                    resp_q.entry <= rd_entry_i;
                    resp_q.ne    <= ~rd_entry_i.e;
                    state        <= S_DONE;
                end
                S_WR: state <= S_DONE;
                S_INV: begin
                    if (&cnt) state <= S_DONE;
                    else      cnt   <= cnt + IDX_W'(1);
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ifc.req_ready  = (state == S_IDLE);
    assign ifc.resp_valid = (state == S_DONE);
    assign ifc.resp_hit   = resp_q.hit;
    assign ifc.resp_idx   = resp_q.idx;
    assign ifc.resp_entry = resp_q.entry;
    assign ifc.resp_ne    = resp_q.ne;
    assign ifc.resp_err   = resp_q.err;

    assign unused_bits = ^{ifc.req_va[12:0], ifc.csr.tlbidx.index[15:IDX_W]};

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// Directed bench for tlb_maint_ctrl with a behavioural TLB array and a response scoreboard.
module tb_tlb_maint_ctrl;
    import tlb_maint_ctrl_pkg::*;

    typedef struct {
        int               due;
        logic             hit;
        logic [IDX_W-1:0] idx;
        logic             ne;
        logic             err;
        logic             chk_e;
        tlb_entry_t       entry;
    } exp_t;

    typedef struct {
        int   c;
        int   idx;
        logic e;
    } wr_t;

    logic             clk;
    logic             rst_n;
    logic [IDX_W-1:0] rd_idx;
    tlb_entry_t       rd_entry;
    tlb_write_req_t   wreq;

    tlb_entry_t mem [TLB_ENTRY_NUM];
    int         cyc = 0;
    int         multi_bad = 0;
    int         bd_mode = 0;
    int         bd_idx = 0;
    tlb_entry_t bd_entry;
    wr_t        wlog[$];
    exp_t       sbq[$];
    int         total = 0;
    int         bad = 0;

    tlb_maint_ctrl_if ifc();

    tlb_maint_ctrl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifc             (ifc),
        .rd_idx_o        (rd_idx),
        .rd_entry_i      (rd_entry),
        .tlb_write_req_o (wreq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    assign rd_entry = mem[rd_idx];

    // Behavioural TLB array: backdoor setup, then DUT write strobes
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bd_mode == 1) begin
            for (int i = 0; i < TLB_ENTRY_NUM; i++) mem[i] <= '0;
        end else if (bd_mode == 2) begin
            mem[bd_idx] <= bd_entry;
        end else if (bd_mode == 3) begin
            for (int i = 0; i < TLB_ENTRY_NUM; i++) mem[i] <= mk_entry(1'b1, 1'b1, 10'd0, 19'(i), 1'b0);
        end else if (wreq.we != '0) begin
            if ($countones(wreq.we) > 1) multi_bad <= multi_bad + 1;
            for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
                if (wreq.we[i]) begin
                    mem[i] <= wreq.entry;
                    wlog.push_back('{c: cyc, idx: i, e: wreq.entry.e});
                end
            end
        end
    end

    function automatic tlb_entry_t mk_entry(input logic e, input logic g, input logic [9:0] asid,
                                            input logic [18:0] vppn, input logic huge);
        tlb_entry_t t = '0;
        t.e = e; t.g = g; t.asid = asid; t.vppn = vppn;
        t.huge_page = huge;
        t.ps = huge ? 6'd21 : 6'd12;
        return t;
    endfunction

    function automatic csr_t mk_csr(input int idx, input logic ne, input logic [5:0] ps,
                                    input logic [18:0] vppn, input logic [9:0] asid, input logic g);
        csr_t c = '0;
        c.tlbidx.index = 16'(idx); c.tlbidx.ne = ne; c.tlbidx.ps = ps;
        c.tlbehi = vppn; c.asid = asid;
        c.tlbelo0 = '{ppn: 20'hABCDE, g: g, mat: 2'd1, plv: 2'd3, d: 1'b1, v: 1'b1};
        c.tlbelo1 = '{ppn: 20'h12345, g: g, mat: 2'd2, plv: 2'd0, d: 1'b0, v: 1'b1};
        return c;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic bd(input int mode, input int idx, input tlb_entry_t e);
        bd_mode = mode; bd_idx = idx; bd_entry = e;
        @(posedge clk); #1;
        bd_mode = 0;
    endtask

    task automatic wait_resp();
        exp_t x;
        int   n = 0;
        while (!ifc.resp_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        x = sbq.pop_front();
        chk("resp_seen",  ifc.resp_valid, 1'b1);
        chk("resp_cycle", cyc, x.due);
        chk("resp_hit",   ifc.resp_hit, x.hit);
        chk("resp_idx",   ifc.resp_idx, x.idx);
        chk("resp_ne",    ifc.resp_ne, x.ne);
        chk("resp_err",   ifc.resp_err, x.err);
        if (x.chk_e) chk("resp_entry", ifc.resp_entry, x.entry);
        @(posedge clk); #1;
        chk("resp_pulse", ifc.resp_valid, 1'b0);
        chk("ready_back", ifc.req_ready, 1'b1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [4:0] invop, input logic [9:0] asid,
                         input logic [31:0] va, input csr_t c, input int lat,
                         input logic hit, input int idx, input logic ne, input logic err,
                         input logic chk_e, input tlb_entry_t ent, output int t_acc);
        exp_t x;
        ifc.req_op = op; ifc.req_invop = invop; ifc.req_asid = asid;
        ifc.req_va = va; ifc.csr = c; ifc.req_valid = 1'b1;
        t_acc = cyc;
        chk("ready_idle", ifc.req_ready, 1'b1);
        x = '{due: t_acc + lat, hit: hit, idx: IDX_W'(idx), ne: ne, err: err, chk_e: chk_e, entry: ent};
        sbq.push_back(x);
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        chk("ready_busy", ifc.req_ready, 1'b0);
        wait_resp();
    endtask

    initial begin
        int         t1, t2, n_inv, n_keep;
        wr_t        w1, w2;
        tlb_entry_t ew;

        rst_n = 1'b0;
        ifc.req_valid = 1'b0; ifc.req_op = '0; ifc.req_invop = '0;
        ifc.req_asid = '0; ifc.req_va = '0; ifc.csr = '0;
        bd_entry = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready",  ifc.req_ready, 1'b1);
        chk("rst_valid",  ifc.resp_valid, 1'b0);
        chk("rst_hit",    ifc.resp_hit, 1'b0);
        chk("rst_ne",     ifc.resp_ne, 1'b0);
        chk("rst_err",    ifc.resp_err, 1'b0);
        chk("rst_idx",    ifc.resp_idx, '0);
        chk("rst_entry",  ifc.resp_entry, '0);
        chk("rst_wreq",   wreq, '0);
        chk("rst_rd_idx", rd_idx, '0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // WR to index 5, then read it back
        bd(1, 0, '0);
        wlog.delete();
        ew = '0;
        ew.e = 1'b1; ew.huge_page = 1'b0; ew.ps = 6'd12; ew.g = 1'b0;
        ew.asid = 10'h55; ew.vppn = 19'h01234;
        ew.lo0 = '{ppn: 20'hABCDE, plv: 2'd3, mat: 2'd1, d: 1'b1, v: 1'b1};
        ew.lo1 = '{ppn: 20'h12345, plv: 2'd0, mat: 2'd2, d: 1'b0, v: 1'b1};
        issue(3'd2, 5'd0, 10'd0, 32'd0, mk_csr(5, 1'b0, 6'd12, 19'h01234, 10'h55, 1'b0),
              2, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0, t1);
        chk("wr_count", wlog.size(), 1);
        w1 = wlog.pop_front();
        chk("wr_idx",   w1.idx, 5);
        chk("wr_cycle", w1.c, t1 + 1);
        issue(3'd1, 5'd0, 10'd0, 32'd0, mk_csr(5, 1'b1, 6'd21, 19'h7FFFF, 10'h3FF, 1'b1),
              2, 1'b0, 0, 1'b0, 1'b0, 1'b1, ew, t1);

        // SRCH: hit at 9, asid miss, huge-page hit at 20
        bd(1, 0, '0);
        bd(2, 9, mk_entry(1'b1, 1'b0, 10'h3, 19'h2A5A5, 1'b0));
        bd(2, 20, mk_entry(1'b1, 1'b1, 10'h0, 19'h71C00, 1'b1));
        issue(3'd0, 5'd0, 10'd0, 32'd0, mk_csr(0, 1'b0, 6'd12, 19'h2A5A5, 10'h3, 1'b0),
              11, 1'b1, 9, 1'b0, 1'b0, 1'b0, '0, t1);
        issue(3'd0, 5'd0, 10'd0, 32'd0, mk_csr(0, 1'b0, 6'd12, 19'h2A5A5, 10'h4, 1'b0),
              65, 1'b0, 0, 1'b1, 1'b0, 1'b0, '0, t1);
        issue(3'd0, 5'd0, 10'd0, 32'd0, mk_csr(0, 1'b0, 6'd12, 19'h71C55, 10'h7, 1'b0),
              22, 1'b1, 20, 1'b0, 1'b0, 1'b0, '0, t1);

        // INV invop 5 then invop 6 over a small population
        bd(1, 0, '0);
        bd(2, 3, mk_entry(1'b1, 1'b0, 10'h3, 19'h00201, 1'b0));
        bd(2, 4, mk_entry(1'b1, 1'b1, 10'h3, 19'h00201, 1'b0));
        bd(2, 7, mk_entry(1'b1, 1'b0, 10'h2, 19'h00201, 1'b0));
        wlog.delete();
        issue(3'd4, 5'd5, 10'h3, 32'h00402000, '0, 65, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0, t1);
        chk("inv5_count", wlog.size(), 1);
        w1 = wlog.pop_front();
        chk("inv5_idx",   w1.idx, 3);
        chk("inv5_cycle", w1.c, t1 + 4);
        chk("inv5_e",     w1.e, 1'b0);
        chk("inv5_keep4", mem[4].e, 1'b1);
        wlog.delete();
        issue(3'd4, 5'd6, 10'h2, 32'h00402000, '0, 65, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0, t1);
        chk("inv6_count", wlog.size(), 2);
        w1 = wlog.pop_front();
        w2 = wlog.pop_front();
        chk("inv6_idx_a", w1.idx, 4);
        chk("inv6_cyc_a", w1.c, t1 + 5);
        chk("inv6_idx_b", w2.idx, 7);
        chk("inv6_cyc_b", w2.c, t1 + 8);

        // FILL twice, then illegal requests
        wlog.delete();
        issue(3'd3, 5'd0, 10'd0, 32'd0, mk_csr(0, 1'b0, 6'd12, 19'h00011, 10'h1, 1'b0),
              2, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0, t1);
        repeat (2) begin @(posedge clk); #1; end
        issue(3'd3, 5'd0, 10'd0, 32'd0, mk_csr(0, 1'b0, 6'd12, 19'h00022, 10'h1, 1'b0),
              2, 1'b0, 0, 1'b0, 1'b0, 1'b0, '0, t2);
        chk("fill_count", wlog.size(), 2);
        w1 = wlog.pop_front();
        w2 = wlog.pop_front();
        chk("fill_cyc_a", w1.c, t1 + 1);
        chk("fill_cyc_b", w2.c, t2 + 1);
        chk("fill_diff",  6'(w2.idx - w1.idx), 6'(w2.c - w1.c));
        wlog.delete();
        issue(3'd4, 5'd7, 10'd0, 32'd0, '0, 2, 1'b0, 0, 1'b0, 1'b1, 1'b0, '0, t1);
        issue(3'd6, 5'd0, 10'd0, 32'd0, mk_csr(1, 1'b0, 6'd12, 19'h1, 10'h1, 1'b0),
              2, 1'b0, 0, 1'b0, 1'b1, 1'b0, '0, t1);
        chk("err_nowrite", wlog.size(), 0);

        // Reset in the middle of an invop-0 scan
        bd(3, 0, '0);
        wlog.delete();
        ifc.req_op = 3'd4; ifc.req_invop = 5'd0; ifc.req_valid = 1'b1;
        t1 = cyc;
        @(posedge clk); #1;
        ifc.req_valid = 1'b0;
        for (int i = 0; i < 40 && cyc < t1 + 20; i++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_ready",  ifc.req_ready, 1'b1);
        chk("mid_valid",  ifc.resp_valid, 1'b0);
        chk("mid_hit",    ifc.resp_hit, 1'b0);
        chk("mid_ne",     ifc.resp_ne, 1'b0);
        chk("mid_err",    ifc.resp_err, 1'b0);
        chk("mid_idx",    ifc.resp_idx, '0);
        chk("mid_entry",  ifc.resp_entry, '0);
        chk("mid_wreq",   wreq, '0);
        chk("mid_rd_idx", rd_idx, '0);
        chk("mid_writes", wlog.size(), 19);
        n_inv = 0;
        n_keep = 0;
        for (int i = 0; i < TLB_ENTRY_NUM; i++) begin
            if (i < 19 && !mem[i].e) n_inv++;
            if (i >= 19 && mem[i].e) n_keep++;
        end
        chk("mid_invalidated", n_inv, 19);
        chk("mid_untouched",   n_keep, 45);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'd1, 5'd0, 10'd0, 32'd0, mk_csr(30, 1'b0, 6'd12, 19'h0, 10'h0, 1'b0),
              2, 1'b0, 0, 1'b0, 1'b0, 1'b1, mk_entry(1'b1, 1'b1, 10'd0, 19'd30, 1'b0), t1);

        chk("onehot", multi_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
